// File: rtl/l15_req_arbiter.sv
// l15_req_arbiter: round-robin sharing of one L1.5 request/return port between NumReq requesters,
// with ID-steered returns and per-requester outstanding-transaction throttling.
module l15_req_arbiter #(
    parameter int NumReq         = 2,
    parameter int ReqWidth       = 128,
    parameter int RtrnWidth      = 256,
    parameter int MaxOutstanding = 4,
    localparam int IdW           = $clog2(NumReq),
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_l,
    input  logic [NumReq-1:0]          req_val_i,
    input  logic [NumReq*ReqWidth-1:0] req_data_i,
    output logic [NumReq-1:0]          req_ack_o,
    output logic                       l15_val_o,
    output logic [ReqWidth-1:0]        l15_data_o,
    output logic [IdW-1:0]             l15_id_o,
    input  logic                       l15_ack_i,
    input  logic                       rtrn_val_i,
    input  logic [RtrnWidth-1:0]       rtrn_data_i,
    input  logic [IdW-1:0]             rtrn_id_i,
    input  logic                       rtrn_noresp_i,
    output logic [NumReq-1:0]          rtrn_val_o,
    output logic [RtrnWidth-1:0]       rtrn_data_o,
    output logic                       busy_o
);
    typedef enum logic {IDLE, ISSUE} state_e;
    state_e              state_q, state_d;
    logic [IdW-1:0]      ptr_q, gnt;
    logic [CntW-1:0]     cnt_q [NumReq];
    logic [NumReq-1:0]   elig, dec, cnt_nz, cnt_zero;
    logic                found, fire, ret_ok, underflow_q;

    always_ff @(posedge clk_i or negedge reset_l)
        if (!reset_l) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb
        state_d = (state_q == IDLE) ? (found ? ISSUE : IDLE) : (l15_ack_i ? IDLE : ISSUE);

    always_comb begin
        l15_val_o = state_q == ISSUE;
        fire      = l15_val_o && l15_ack_i;
        req_ack_o = fire ? NumReq'(1) << l15_id_o : '0;
        busy_o    = l15_val_o || |cnt_nz;
    end

    // First eligible requester at or after the round-robin pointer, with wrap-around.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NumReq; k++) begin
            elig[k]     = req_val_i[k] && cnt_q[k] < CntW'(MaxOutstanding);
            cnt_nz[k]   = cnt_q[k] != '0;
            cnt_zero[k] = !cnt_nz[k];
        end
        for (int i = 0; i < NumReq; i++)
            if (!found && elig[(int'(ptr_q) + i) % NumReq]) begin
                found = 1'b1;
                gnt   = IdW'((int'(ptr_q) + i) % NumReq);
            end
    end

    // Out-of-range IDs and noresp returns never touch a counter.
    always_comb begin
        ret_ok = rtrn_val_i && !rtrn_noresp_i && int'(rtrn_id_i) < NumReq;
        dec    = ret_ok ? NumReq'(1) << rtrn_id_i : '0;
    end

    always_ff @(posedge clk_i or negedge reset_l)
        if (!reset_l) begin
            l15_data_o <= '0;
            l15_id_o   <= '0;
            ptr_q      <= '0;
        end else begin
            if (state_q == IDLE && found) begin
                l15_data_o <= req_data_i[int'(gnt)*ReqWidth +: ReqWidth];
                l15_id_o   <= gnt;
            end
            if (fire) ptr_q <= IdW'((int'(l15_id_o) + 1) % NumReq);
        end

    always_ff @(posedge clk_i or negedge reset_l)
        if (!reset_l) begin
            for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < NumReq; k++)
                if (req_ack_o[k] && !dec[k])                   cnt_q[k] <= cnt_q[k] + CntW'(1);
                else if (dec[k] && !req_ack_o[k] && cnt_nz[k]) cnt_q[k] <= cnt_q[k] - CntW'(1);
            if (|(dec & ~req_ack_o & cnt_zero)) underflow_q <= 1'b1;
        end

    always_ff @(posedge clk_i or negedge reset_l)
        if (!reset_l) begin
            rtrn_val_o  <= '0;
            rtrn_data_o <= '0;
        end else begin
            rtrn_val_o  <= (rtrn_val_i && rtrn_noresp_i) ? '1 : dec;
            rtrn_data_o <= rtrn_data_i;
        end

    // Returns without a matching request indicate an L1.5 protocol problem.
    assert property (@(posedge clk_i) disable iff (!reset_l) !underflow_q)
        else $warning("l15_req_arbiter: return counter underflow");
endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Shares one L1.5 request/return port between NumReq independent requesters, e.g. the core cache subsystem plus a debug/init engine.
- Request side: round-robin arbitration with a val/ack handshake. The granted request is held stable until the L1.5 acknowledges it.
- Return side: returns are steered back to the originating requester by an ID field carried in the return.
- A per-requester outstanding-transaction counter throttles each requester.

Parameters:
- NumReq, 2, number of requesters (2..8).
- ReqWidth, 128, width of a flattened request payload.
- RtrnWidth, 256, width of a flattened return payload.
- MaxOutstanding, 4, maximum un-returned requests per requester (1..15).

Ports:
- clk_i  in  1  clock.
- reset_l  in  1  asynchronous active-low reset.
- req_val_i  in  NumReq  per-requester request valid.
- req_data_i  in  NumReq*ReqWidth  per-requester payload; requester k occupies bits [k*ReqWidth +: ReqWidth].
- req_ack_o  out  NumReq  one-hot acknowledge; the pulse consumes that requester's request.
- l15_val_o  out  1  request valid to L1.5.
- l15_data_o  out  ReqWidth  request payload to L1.5.
- l15_id_o  out  $clog2(NumReq)  requester index sent with the request; the L1.5 echoes it in the return.
- l15_ack_i  in  1  L1.5 header ack.
- rtrn_val_i  in  1  return valid from L1.5.
- rtrn_data_i  in  RtrnWidth  return payload.
- rtrn_id_i  in  $clog2(NumReq)  echoed requester index.
- rtrn_noresp_i  in  1  return has no matching request (interrupt/invalidation); broadcast to all requesters, no counter change.
- rtrn_val_o  out  NumReq  per-requester return valid.
- rtrn_data_o  out  RtrnWidth  return payload, shared by all requesters.
- busy_o  out  1  any outstanding counter non-zero, or l15_val_o high.

Behaviour:
- Reset (async assert, sync release on clk_i) clears: l15_val_o, req_ack_o, rtrn_val_o, busy_o, all counters, round-robin pointer (=0), state.
- State machine:
  - IDLE: compute the eligible set. Requester k is eligible when req_val_i[k]=1 and cnt[k] < MaxOutstanding.
  - IDLE, eligible set non-empty: choose the first eligible index at or after ptr, with wrap-around. Register its payload into l15_data_o and its index into l15_id_o. Next cycle: l15_val_o=1, state=ISSUE.
  - IDLE, eligible set empty: remain in IDLE.
  - ISSUE: l15_val_o, l15_data_o and l15_id_o are held constant.
  - ISSUE, l15_ack_i=1: in the same cycle req_ack_o[g]=1 for exactly one cycle and cnt[g] increments. Next cycle: ptr=(g+1) mod NumReq, l15_val_o=0, state=IDLE.
- Minimum spacing between grants is 2 cycles: IDLE decide, then ISSUE. Request-to-l15_val_o latency is 1 cycle.
- Requester rule: a requester must hold req_val_i and its payload stable until it receives req_ack_o. The block does not sample payload changes during ISSUE.
- Returns: purely registered, 1-cycle latency.
  - rtrn_val_o[rtrn_id_i] <= rtrn_val_i & ~rtrn_noresp_i.
  - If rtrn_noresp_i=1, all rtrn_val_o bits are set.
  - rtrn_data_o <= rtrn_data_i.
  - Returns are always accepted (no backpressure).
- Counter decrement: a non-noresp return decrements cnt[rtrn_id_i] in the cycle rtrn_val_i is sampled.
- Simultaneous ack and return to the same index: the counter is unchanged (+1-1).
- Counter underflow (return with cnt=0): the counter saturates at 0. A sticky debug flag is set; assertion only, no port.
- Out-of-range rtrn_id_i (>= NumReq): the return is dropped.
- The counter check applies only at grant time. A requester whose counter becomes full while in ISSUE still completes that ISSUE.
- Reset mid-ISSUE: l15_val_o drops immediately and the in-flight request is abandoned.
- Widths: counters are $clog2(MaxOutstanding+1) bits; ptr is $clog2(NumReq) bits.

Test Plan:
- Single requester: req_val_i=01, l15_ack_i asserted 3 cycles after l15_val_o. Expect l15_val_o at cycle +1, req_ack_o=01 on the ack cycle, l15_data_o equal to req0 payload throughout, l15_id_o=0.
- Fairness: NumReq=2, both requesting continuously, immediate ack. Expect grants alternating 0,1,0,1; each grant 2 cycles apart.
- Throttle: MaxOutstanding=4, requester 1 issues 4 requests with no returns. The 5th is not granted and requester 0 is served instead. One return with rtrn_id_i=1 makes requester 1 grantable on the next IDLE.
- Return steering: rtrn_val_i=1, rtrn_id_i=1. Expect rtrn_val_o=10 one cycle later, cnt[1] decremented, data passed through.
- Broadcast: rtrn_noresp_i=1. Expect rtrn_val_o=all ones and counters unchanged. Simultaneous ack and return on index 0 leaves cnt[0] constant.
- Reset during ISSUE: deassert reset_l while l15_val_o=1. Expect l15_val_o, rtrn_val_o and busy_o at 0 asynchronously, and ptr=0 after release.
